// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg: shared FSM state type and Funct3 access-size encodings for the LSU.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align: byte-lane enables, store replication, load extraction/extension
// and misalignment detection. Purely combinational. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = load_word[7:0];
    case (addr_lo)
      2'd1:    sel_byte = load_word[15:8];
      2'd2:    sel_byte = load_word[23:16];
      2'd3:    sel_byte = load_word[31:24];
      default: sel_byte = load_word[7:0];
    endcase
    sel_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
  end

  always_comb begin
    load_data = load_word;
    case (funct3)
      LB:      load_data = {{24{sel_byte[7]}}, sel_byte};
      LH:      load_data = {{16{sel_half[15]}}, sel_half};
      LBU:     load_data = {24'b0, sel_byte};
      LHU:     load_data = {16'b0, sel_half};
      default: load_data = load_word;
    endcase
  end

  // Stores only know byte/half/word; the unsigned encodings are illegal there.
  always_comb begin
    misalign = 1'b1;
    case (funct3)
      LB:      misalign = 1'b0;
      LH:      misalign = addr_lo[0];
      LW:      misalign = |addr_lo;
      LBU:     misalign = is_store;
      LHU:     misalign = is_store | addr_lo[0];
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    byte_en    = 4'b0000;
    store_word = store_data;
    case (funct3)
      SB: begin
        byte_en    = 4'b0001 << addr_lo;
        store_word = {4{store_data[7:0]}};
      end
      SH: begin
        byte_en    = 4'b0011 << addr_lo;
        store_word = {2{store_data[15:0]}};
      end
      SW:      byte_en = 4'b1111;
      LBU:     byte_en = 4'b0001 << addr_lo;
      LHU:     byte_en = 4'b0011 << addr_lo;
      default: byte_en = 4'b0000;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit: M-stage bus master FSM issuing one load/store per
// instruction, stalling the pipeline until the bus completes. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DATA_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  lsu_state_e            state;
  lsu_state_e            state_next;
  logic                  is_store;
  logic                  valid;
  logic                  misalign;
  logic                  issue;
  logic [DATA_WIDTH-1:0] load_data;

  // A store wins when both load and store are flagged.
  assign is_store = MemWriteM;
  assign valid    = (ResultSrcM == 2'b01) | MemWriteM;
  assign issue    = valid & ~misalign;

  assign bus_addr = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
  assign bus_we   = is_store;

  lsu_align u_align (
    .funct3     (Funct3M),
    .addr_lo    (ALUResultM[1:0]),
    .is_store   (is_store),
    .store_data (WriteDataM),
    .load_word  (bus_rdata),
    .byte_en    (bus_be),
    .store_word (bus_wdata),
    .load_data  (load_data),
    .misalign   (misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ReadDataM <= '0;
    end else if (state == WAIT && bus_rvalid) begin
      ReadDataM <= load_data;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (issue) begin
          if (bus_gnt) state_next = is_store ? DONE : WAIT;
          else         state_next = REQ;
        end
      end
      // A same-cycle rvalid in REQ belongs to nobody; only the grant counts.
      REQ: begin
        if (bus_gnt) state_next = is_store ? DONE : WAIT;
      end
      WAIT: begin
        if (bus_rvalid) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus_req   = 1'b0;
    StallM    = 1'b0;
    MisalignM = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          bus_req   = issue;
          StallM    = issue;
          MisalignM = valid & misalign;
        end
        REQ: begin
          bus_req = 1'b1;
          StallM  = 1'b1;
        end
        WAIT:    StallM = 1'b1;
        default: StallM = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit: directed scoreboard bench for load_store_unit.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = 32'h0;

  int          stall_n, req_n, mis_n, grant_n;
  logic [3:0]  seen_be;
  logic [31:0] seen_addr, seen_wdata;
  logic        seen_we;
  logic [31:0] leave_state;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ResultSrcM = 2'b00; MemWriteM = 1'b0; Funct3M = 3'b000;
    ALUResultM = 32'h0; WriteDataM = 32'h0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
  endtask

  // Presents one access, grants after gnt_dly cycles, returns rdata rv_dly
  // cycles after the grant; stray adds an rvalid on the grant-request cycle.
  task automatic run_access(input string tag, input bit st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int gnt_dly, input int rv_dly,
                            input logic [31:0] rd, input bit stray);
    int          gnt_cyc;
    bit          left;
    bit          real_rv;
    logic [31:0] exp_rd;
    gnt_cyc = -1; left = 1'b0;
    stall_n = 0; req_n = 0; mis_n = 0; grant_n = 0;
    seen_be = 4'h0; seen_addr = 32'h0; seen_wdata = 32'h0; seen_we = 1'b0;
    leave_state = 32'hFFFF_FFFF;
    ResultSrcM = st ? 2'b00 : 2'b01; MemWriteM = st; Funct3M = f3;
    ALUResultM = addr; WriteDataM = wd;
    for (int c = 0; c < 20 && !left; c++) begin
      real_rv    = (gnt_cyc >= 0) && (c == gnt_cyc + rv_dly);
      bus_gnt    = (c >= gnt_dly) && (gnt_cyc < 0);
      bus_rvalid = real_rv || (stray && c == gnt_dly);
      bus_rdata  = real_rv ? rd : (stray ? 32'h5555_5555 : 32'h0);
      @(negedge clk);
      if (StallM)    stall_n++;
      if (bus_req)   req_n++;
      if (MisalignM) mis_n++;
      if (bus_req && bus_gnt) begin
        grant_n++; gnt_cyc = c;
        seen_be = bus_be; seen_addr = bus_addr; seen_wdata = bus_wdata; seen_we = bus_we;
      end
      if (!StallM) begin
        left = 1'b1;
        leave_state = 32'(dut.state);
        exp_rd = (exp_q.size() != 0) ? exp_q.pop_front() : last_rd;
        last_rd = exp_rd;
        check({tag, " ReadDataM"}, ReadDataM, exp_rd);
      end
      @(posedge clk); #1;
    end
    check({tag, " completed"}, 32'(left), 32'd1);
    idle_inputs();
  endtask

  int grants_total;

  initial begin
    idle_inputs();
    // Reset with a load presented: outputs must stay quiet.
    ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ReadDataM", ReadDataM, 32'h0);
    check("rst StallM", 32'(StallM), 32'd0);
    check("rst bus_req", 32'(bus_req), 32'd0);
    check("rst MisalignM", 32'(MisalignM), 32'd0);
    check("rst state", 32'(dut.state), 32'(IDLE));
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_access("sw", 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 1, 32'h0, 1'b0);
    check("sw be", 32'(seen_be), 32'h0000_000F);
    check("sw wdata", seen_wdata, 32'hDEAD_BEEF);
    check("sw addr", seen_addr, 32'h100);
    check("sw we", 32'(seen_we), 32'd1);
    check("sw stall", stall_n, 1);
    check("sw grants", grant_n, 1);
    check("sw leave", leave_state, 32'(DONE));

    exp_q.push_back(32'hFFFF_FF80);
    run_access("lb", 1'b0, 3'b000, 32'h103, 32'h0, 2, 1, 32'h80FF_0000, 1'b0);
    check("lb stall", stall_n, 4);
    check("lb grants", grant_n, 1);
    check("lb addr", seen_addr, 32'h100);
    check("lb leave", leave_state, 32'(DONE));

    exp_q.push_back(32'h0000_8001);
    run_access("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 1, 1, 32'h8001_1234, 1'b0);
    check("lhu stall", stall_n, 3);

    exp_q.push_back(32'hFFFF_8001);
    run_access("lh", 1'b0, 3'b001, 32'h102, 32'h0, 0, 1, 32'h8001_1234, 1'b0);
    check("lh stall", stall_n, 2);

    run_access("sh mis", 1'b1, 3'b001, 32'h101, 32'h1234, 0, 1, 32'h0, 1'b0);
    check("sh mis pulses", mis_n, 1);
    check("sh mis req", req_n, 0);
    check("sh mis stall", stall_n, 0);
    @(negedge clk);
    check("sh mis after", 32'(MisalignM), 32'd0);
    @(posedge clk); #1;

    run_access("sb", 1'b1, 3'b000, 32'h102, 32'h0000_00AB, 0, 1, 32'h0, 1'b0);
    check("sb be", 32'(seen_be), 32'h0000_0004);
    check("sb wdata", seen_wdata, 32'hABAB_ABAB);
    check("sb addr", seen_addr, 32'h100);

    run_access("sh", 1'b1, 3'b001, 32'h102, 32'h0000_1234, 1, 1, 32'h0, 1'b0);
    check("sh be", 32'(seen_be), 32'h0000_000C);
    check("sh wdata", seen_wdata, 32'h1234_1234);
    check("sh stall", stall_n, 2);

    run_access("bad f3", 1'b0, 3'b011, 32'h0, 32'h0, 0, 1, 32'h0, 1'b0);
    check("bad f3 mis", mis_n, 1);
    check("bad f3 req", req_n, 0);

    exp_q.push_back(32'hCAFE_F00D);
    run_access("gnt+rv", 1'b0, 3'b010, 32'h200, 32'h0, 1, 2, 32'hCAFE_F00D, 1'b1);
    check("gnt+rv stall", stall_n, 4);

    exp_q.push_back(32'h1111_1111);
    exp_q.push_back(32'h2222_2222);
    run_access("b2b0", 1'b0, 3'b010, 32'h0, 32'h0, 0, 1, 32'h1111_1111, 1'b0);
    grants_total = grant_n;
    check("b2b0 leave", leave_state, 32'(DONE));
    run_access("b2b1", 1'b0, 3'b010, 32'h4, 32'h0, 0, 1, 32'h2222_2222, 1'b0);
    grants_total += grant_n;
    check("b2b grants", grants_total, 2);
    check("b2b1 addr", seen_addr, 32'h4);

    // Reset while waiting for read data, then a stray rvalid.
    ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h300; bus_gnt = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    check("rstw in WAIT", 32'(dut.state), 32'(WAIT));
    #2 rst_n = 1'b0;
    #1;
    check("rstw state", 32'(dut.state), 32'(IDLE));
    check("rstw ReadDataM", ReadDataM, 32'h0);
    check("rstw StallM", 32'(StallM), 32'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    check("rstw no capture", ReadDataM, 32'h0);
    check("rstw idle", 32'(dut.state), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data/address width; only 32 is supported.
REQ-002 SHALL have ports: clk  in  1  clock; all state updates on the rising edge.
REQ-003 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have inputs from the execute/memory register: ResultSrcM in 2 (2'b01 = load); MemWriteM in 1 (store); Funct3M in 3 (access size/sign); ALUResultM in 32 (byte address); WriteDataM in 32 (store data).
REQ-005 SHALL have outputs to the pipeline: ReadDataM out 32 (formatted load data); StallM out 1 (hold PC, F/D/E/M registers); MisalignM out 1 (misaligned access pulse).
REQ-006 SHALL have bus outputs: bus_req 1; bus_we 1; bus_addr 32 (word-aligned); bus_be 4 (byte enables); bus_wdata 32.
REQ-007 SHALL have bus inputs: bus_gnt 1 (request accepted this cycle); bus_rvalid 1 (read data valid); bus_rdata 32.

Function
REQ-008 SHALL treat an access as valid when ResultSrcM==2'b01 (load) or MemWriteM==1 (store); both high SHALL be treated as a store.
REQ-009 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-010 IDLE: aligned valid access SHALL assert bus_req and StallM combinationally; if bus_gnt then go to WAIT for a load or DONE for a store; else go to REQ.
REQ-011 REQ: SHALL hold bus_req=1 and StallM=1; on bus_gnt go to WAIT (load) or DONE (store).
REQ-012 WAIT: StallM=1, bus_req=0; on bus_rvalid capture formatted bus_rdata into ReadDataM and go to DONE.
REQ-013 DONE: StallM=0 for exactly one cycle so the instruction leaves M; then unconditionally go to IDLE. An access seen in DONE SHALL NOT issue.
REQ-014 bus_addr SHALL be {ALUResultM[31:2],2'b00}; bus_we=1 for stores; bus_wdata SHALL be WriteDataM byte-replicated (SB) or halfword-replicated (SH), or passed unchanged (SW).
REQ-015 bus_be for SB SHALL be 4'b0001<<addr[1:0]; for SH, 4'b0011<<addr[1:0]; for SW, 4'b1111.
REQ-016 Loads SHALL select the byte or halfword at addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW pass through; Funct3 encodings are 000/001/010/100/101.
REQ-017 An access is misaligned when it is a halfword with addr[0]=1, or a word with addr[1:0]!=0.
REQ-018 A misaligned access SHALL set MisalignM=1 for one cycle in IDLE, with no bus_req and no stall; ReadDataM SHALL be held.
REQ-019 An unsupported Funct3 SHALL be treated as misaligned.
REQ-020 ReadDataM SHALL hold its last value except on WAIT-state capture; latency from grant to data is 1 cycle plus bus delay.
REQ-021 bus_rvalid outside WAIT SHALL be ignored.
REQ-022 A bus_gnt and bus_rvalid in the same cycle while in REQ SHALL be handled as a grant only.

Reset
REQ-023 While rst_n=0: state=IDLE and ReadDataM=0; bus_req, StallM and MisalignM SHALL be 0.
REQ-024 Reset asserted mid-transaction SHALL abandon it immediately; any later bus_rvalid SHALL be ignored.

Structure
REQ-025 Shared package lsu_pkg SHALL hold the state enum and the Funct3 size constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-026 Byte-lane and extension logic SHALL live in a combinational sub-module lsu_align; the FSM and registers stay in load_store_unit.

Verification
REQ-027 Test SW: addr 0x100, data 0xDEADBEEF, gnt the same cycle -> bus_be=1111, StallM high for 1 cycle, then DONE.
REQ-028 Test LB: addr 0x103, gnt delayed 2 cycles, rdata 0x80FF_0000 after 1 cycle -> ReadDataM=0xFFFFFF80, StallM high for 4 cycles.
REQ-029 Test LHU: addr 0x102, rdata 0x8001_1234 -> ReadDataM=0x00008001; repeat with LH -> 0xFFFF8001.
REQ-030 Test SH: addr 0x101 -> MisalignM pulses once, bus_req never rises, StallM stays 0.
REQ-031 Test reset: rst_n=0 while in WAIT, then a stray rvalid arrives -> state=IDLE, ReadDataM=0, no capture.
REQ-032 Test back-to-back: loads at 0x0 and 0x4 -> exactly two bus_req grants, with a DONE cycle between them.
